// File: rtl/if_stage_prefetch.sv
// rtl/if_stage_prefetch.sv - decoupled prefetching instruction fetch stage
module if_stage_prefetch #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [ILEN-1:0]            imem_rsp_data,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            id_pc,
  output logic [ILEN-1:0]            id_instr,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_tgt;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];
  logic            started;
  logic            req_fire;
  logic            drop_rsp;
  logic            push;
  logic            pop;

  // Redirect targets are forced to word alignment.
  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  // Every in-flight request and every buffered entry holds one credit.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};

  assign imem_req_addr = fetch_pc;
  assign fifo_count    = count;
  assign id_valid      = (count != '0);
  assign id_pc         = pc_mem[rd_ptr];
  assign id_instr      = instr_mem[rd_ptr];

  // Handshake decode: issue gating, response keep/drop, decode pop.
  always_comb begin
    imem_req_valid = 1'b0;
    req_fire       = 1'b0;
    drop_rsp       = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    imem_req_valid = started && (credit_used < (CW+1)'(DEPTH)) && !redirect_valid;
    req_fire       = imem_req_valid && imem_req_ready;
    drop_rsp       = imem_rsp_valid && ((drop_cnt != '0) || redirect_valid);
    push           = imem_rsp_valid && !drop_rsp;
    pop            = id_valid && id_ready && !redirect_valid;
  end

  // Fetch/response PC tracking and in-flight accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        // Pending drops are themselves in flight, so the whole surviving
        // in-flight population becomes the new drop count.
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (push) begin
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (drop_rsp) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  // FIFO pointers and occupancy; a flush keeps rd_ptr so the head output holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// tb/tb_if_stage_prefetch.sv - scoreboard testbench for if_stage_prefetch
module tb_if_stage_prefetch;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [ILEN-1:0] imem_rsp_data = '0;
  logic            id_valid;
  logic            id_ready = 1'b0;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] id_instr;
  logic [CW-1:0]   fifo_count;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  int deliv_cnt = 0;
  int acc_cnt = 0;
  logic [XLEN-1:0] exp_fetch = '0;

  typedef struct { logic [XLEN-1:0] addr; int due; } mreq_t;
  typedef struct { logic [XLEN-1:0] pc; logic [ILEN-1:0] instr; } exp_t;
  mreq_t mem_q[$];
  exp_t  exp_q[$];

  if_stage_prefetch #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: fixed latency, in order, reset alongside the DUT.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (!rst) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
      mem_q.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  // Scoreboard: accepted requests since the last redirect must reach decode in order.
  always begin
    @(negedge clk);
    #3;
    if (!rst) begin
      exp_q.delete();
      exp_fetch = '0;
    end else begin
      if (redirect_valid) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL redirect_req_valid: got %b expected 0", imem_req_valid);
        end
        exp_q.delete();
        exp_fetch = redirect_pc & ~64'h3;
      end else if (id_valid && id_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h with nothing expected", id_pc);
        end else begin
          if (id_pc !== exp_q[0].pc || id_instr !== exp_q[0].instr) begin
            errors++;
            $display("FAIL sb_data: got pc=%h instr=%h expected pc=%h instr=%h",
                     id_pc, id_instr, exp_q[0].pc, exp_q[0].instr);
          end
          exp_q.delete(0);
        end
        deliv_cnt++;
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (imem_req_addr !== exp_fetch) begin
          errors++;
          $display("FAIL req_addr_seq: got %h expected %h", imem_req_addr, exp_fetch);
        end
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        exp_q.push_back('{pc: imem_req_addr, instr: instr_of(imem_req_addr)});
        exp_fetch = imem_req_addr + 64'd4;
        acc_cnt++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b0;
    next_cycle();
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || fifo_count !== '0 ||
        id_pc !== '0 || id_instr !== '0) begin
      errors++;
      $display("FAIL reset_state: got req_valid=%b id_valid=%b count=%0d pc=%h instr=%h expected all zero",
               imem_req_valid, id_valid, fifo_count, id_pc, id_instr);
    end
    next_cycle();
    rst = 1'b1;
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early: got req_valid=%b expected 0", imem_req_valid);
    end
    next_cycle();
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_first_req: got valid=%b addr=%h expected 1 / 0", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    int d0;
    next_cycle();
    lat = 1;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    repeat (4) next_cycle();
    d0 = deliv_cnt;
    for (int i = 0; i < 10; i++) begin
      mid_cycle();
      checks++;
      if (id_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_id_valid: cycle %0d got %b expected 1", i, id_valid);
      end
      next_cycle();
    end
    checks++;
    if (deliv_cnt - d0 != 10) begin
      errors++;
      $display("FAIL stream_rate: got %0d deliveries expected 10", deliv_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int a0;
    do_reset();
    lat = 1;
    imem_req_ready = 1'b1;
    id_ready = 1'b0;
    a0 = acc_cnt;
    repeat (12) next_cycle();
    mid_cycle();
    checks++;
    if (acc_cnt - a0 != 4 || imem_req_valid !== 1'b0 || fifo_count !== CW'(4) ||
        id_valid !== 1'b1 || id_pc !== 64'h0) begin
      errors++;
      $display("FAIL bp_full: got acc=%0d valid=%b count=%0d id_valid=%b pc=%h expected 4/0/4/1/0",
               acc_cnt - a0, imem_req_valid, fifo_count, id_valid, id_pc);
    end
    next_cycle();
    id_ready = 1'b1;
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_pop_cycle: got req_valid=%b expected 0", imem_req_valid);
    end
    next_cycle();
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h10 || fifo_count !== CW'(3)) begin
      errors++;
      $display("FAIL bp_resume: got valid=%b addr=%h count=%0d expected 1/10/3",
               imem_req_valid, imem_req_addr, fifo_count);
    end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    lat = 5;
    id_ready = 1'b1;
    next_cycle();
    imem_req_ready = 1'b1;
    repeat (3) next_cycle();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h1002;
    next_cycle();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
      errors++;
      $display("FAIL stale_new_req: got valid=%b addr=%h expected 1/1000", imem_req_valid, imem_req_addr);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (id_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_not_delivered: cycle %0d got id_valid=%b pc=%h expected 0", i, id_valid, id_pc);
      end
      next_cycle();
      mid_cycle();
    end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 64'h1000) begin
      errors++;
      $display("FAIL stale_first_pc: got valid=%b pc=%h expected 1/1000", id_valid, id_pc);
    end
  endtask

  task automatic test_redirect_with_rsp();
    bit found = 0;
    do_reset();
    lat = 2;
    id_ready = 1'b0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      next_cycle();
      mid_cycle();
      if (imem_rsp_valid && fifo_count >= CW'(2)) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rsp_redirect_setup: got no response with buffered entries expected one within 20 cycles");
    end else begin
      redirect_valid = 1'b1;
      redirect_pc = 64'h2000;
      id_ready = 1'b1;
      next_cycle();
      redirect_valid = 1'b0;
      mid_cycle();
      checks++;
      if (fifo_count !== '0 || id_valid !== 1'b0) begin
        errors++;
        $display("FAIL rsp_redirect_flush: got count=%0d id_valid=%b expected 0/0", fifo_count, id_valid);
      end
      for (int i = 0; i < 20 && id_valid !== 1'b1; i++) begin
        next_cycle();
        mid_cycle();
      end
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 64'h2000) begin
        errors++;
        $display("FAIL rsp_redirect_first: got valid=%b pc=%h expected 1/2000", id_valid, id_pc);
      end
    end
  endtask

  task automatic test_req_stall();
    do_reset();
    lat = 1;
    id_ready = 1'b1;
    imem_req_ready = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      mid_cycle();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got valid=%b addr=%h expected 1/0", i, imem_req_valid, imem_req_addr);
      end
      next_cycle();
    end
    imem_req_ready = 1'b1;
    next_cycle();
    imem_req_ready = 1'b0;
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4) begin
      errors++;
      $display("FAIL stall_advance: got valid=%b addr=%h expected 1/4", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_wrap();
    lat = 1;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    next_cycle();
    redirect_valid = 1'b0;
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top: got valid=%b addr=%h expected 1/fffffffffffffffc", imem_req_valid, imem_req_addr);
    end
    next_cycle();
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0 || $isunknown(imem_req_addr)) begin
      errors++;
      $display("FAIL wrap_zero: got valid=%b addr=%h expected 1/0", imem_req_valid, imem_req_addr);
    end
    next_cycle();
    mid_cycle();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_deliver_top: got valid=%b pc=%h expected 1/fffffffffffffffc", id_valid, id_pc);
    end
    next_cycle();
    mid_cycle();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 64'h0 || $isunknown(id_instr)) begin
      errors++;
      $display("FAIL wrap_deliver_zero: got valid=%b pc=%h instr=%h expected 1/0", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_back_to_back();
    lat = 3;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (4) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    next_cycle();
    redirect_pc = 64'h4004;
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got req_valid=%b id_valid=%b expected 0/0", imem_req_valid, id_valid);
    end
    next_cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && id_valid !== 1'b1; i++) begin
      mid_cycle();
      if (id_valid !== 1'b1) next_cycle();
    end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 64'h4004) begin
      errors++;
      $display("FAIL b2b_last_wins: got valid=%b pc=%h expected 1/4004", id_valid, id_pc);
    end
  endtask

  task automatic test_reset_mid();
    lat = 2;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (5) next_cycle();
    mid_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || fifo_count !== '0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got valid=%b count=%0d id_valid=%b expected 0/0/0",
               imem_req_valid, fifo_count, id_valid);
    end
    repeat (2) next_cycle();
    rst = 1'b1;
    next_cycle();
    mid_cycle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      errors++;
      $display("FAIL midreset_restart: got valid=%b addr=%h expected 1/0", imem_req_valid, imem_req_addr);
    end
    for (int i = 0; i < 20 && id_valid !== 1'b1; i++) begin
      next_cycle();
      mid_cycle();
    end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 64'h0) begin
      errors++;
      $display("FAIL midreset_first: got valid=%b pc=%h expected 1/0", id_valid, id_pc);
    end
  endtask

  task automatic test_drain();
    next_cycle();
    imem_req_ready = 1'b0;
    id_ready = 1'b1;
    repeat (15) next_cycle();
    checks++;
    if (exp_q.size() != 0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL drain: got %0d undelivered, count=%0d expected 0/0", exp_q.size(), fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_with_rsp();
    test_req_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
